// File: rtl/ssd_bcd_display_driver.sv
// ---------------------------------------------------------------------------
// ssd_bcd_display_driver
//
// Shows a 13-bit unsigned binary value in decimal on a 4-digit common-anode
// seven-segment display. The display stage sits directly after the
// processor's display-select mux.
//
// When the input value differs from the last captured value, an iterative
// double-dabble converter runs, one bit per clock. The result is copied into
// a display register only when the conversion completes. The digit in use is
// time-multiplexed by a free-running refresh counter. Leading zeros are
// blanked, but the ones digit is always shown.
//
// Parameters
//   REFRESH_BITS : width of the refresh counter (>= 3). The top two bits
//                  select the active digit, so each digit dwells for
//                  2^(REFRESH_BITS-2) cycles.
//
// Ports
//   clk     : single clock, all state updates on the rising edge
//   reset   : asynchronous, active-high reset
//   value   : unsigned binary value to display (0..8191)
//   anode   : active-low digit enables, bit 0 = rightmost (ones) digit;
//             registered
//   cathode : active-low segments ordered {g,f,e,d,c,b,a}; registered
//   busy    : high while a conversion is in progress (CONVERT or LOAD)
// ---------------------------------------------------------------------------
module ssd_bcd_display_driver #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        busy
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int                      BIN_BITS     = 13;
    localparam int                      BCD_DIGITS   = 4;
    localparam int                      BCD_BITS     = 4 * BCD_DIGITS;
    localparam int                      SHIFT_BITS   = BCD_BITS + BIN_BITS;
    localparam logic [3:0]              LAST_ITER    = 4'(BIN_BITS - 1);
    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE  = {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    localparam logic [6:0]              SEG_BLANK    = 7'h7F;

    // -----------------------------------------------------------------------
    // FSM state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // -----------------------------------------------------------------------
    // Conversion datapath
    // -----------------------------------------------------------------------
    logic [SHIFT_BITS-1:0] shift_reg, shift_next;
    logic [SHIFT_BITS-1:0] shift_adj;
    logic [3:0]            iter_reg, iter_next;
    logic [BCD_BITS-1:0]   disp_bcd_reg, disp_bcd_next;
    logic [BIN_BITS-1:0]   last_value_reg, last_value_next;

    // -----------------------------------------------------------------------
    // Display multiplexing
    // -----------------------------------------------------------------------
    logic [REFRESH_BITS-1:0] refresh_reg;
    logic [1:0]              sel;
    logic [3:0]              nibble;
    logic [BCD_DIGITS-1:0]   blank;
    logic [3:0]              anode_reg, anode_next;
    logic [6:0]              cathode_reg, cathode_next;

    // -----------------------------------------------------------------------
    // Active-low seven-segment encoding of one BCD digit. Codes 10..15
    // should never reach this point; they are shown as an unlit digit
    // rather than as garbage.
    // -----------------------------------------------------------------------
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // -----------------------------------------------------------------------
    // Double-dabble correction. Each BCD nibble that is 5 or more gets +3
    // before the shift, so that the shift carries into the next decade
    // correctly. The binary part passes through untouched.
    // -----------------------------------------------------------------------
    assign shift_adj[BIN_BITS-1:0] = shift_reg[BIN_BITS-1:0];

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
            logic [3:0] nib;
            assign nib = shift_reg[BIN_BITS + 4*gi +: 4];
            assign shift_adj[BIN_BITS + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        iter_next       = iter_reg;
        disp_bcd_next   = disp_bcd_reg;
        last_value_next = last_value_reg;

        case (state_reg)
            IDLE: begin
                // Only a changed value starts a conversion. Changes that
                // arrive mid-conversion are seen here once LOAD has finished.
                if (value != last_value_reg) begin
                    shift_next      = {{BCD_BITS{1'b0}}, value};
                    last_value_next = value;
                    iter_next       = 4'd0;
                    state_next      = CONVERT;
                end
            end

            CONVERT: begin
                shift_next = shift_adj << 1;
                iter_next  = iter_reg + 4'd1;
                if (iter_reg == LAST_ITER) begin
                    state_next = LOAD;
                end
            end

            LOAD: begin
                disp_bcd_next = shift_reg[SHIFT_BITS-1:BIN_BITS];
                state_next    = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg      <= '0;
            iter_reg       <= 4'd0;
            disp_bcd_reg   <= '0;
            last_value_reg <= '0;
        end else begin
            shift_reg      <= shift_next;
            iter_reg       <= iter_next;
            disp_bcd_reg   <= disp_bcd_next;
            last_value_reg <= last_value_next;
        end
    end

    // -----------------------------------------------------------------------
    // Leading-zero blanking. Digit k is blank when it and every higher
    // digit are zero. The ones digit is always lit, so that 0 is shown as
    // a single "0".
    // -----------------------------------------------------------------------
    assign blank[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < BCD_DIGITS; gi++) begin : g_blank
            assign blank[gi] = ~|disp_bcd_reg[BCD_BITS-1:4*gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Digit selection and segment lookup. These are registered one cycle
    // after the refresh counter, so the outputs lag sel by one clock.
    // -----------------------------------------------------------------------
    assign sel    = refresh_reg[REFRESH_BITS-1 -: 2];
    assign nibble = disp_bcd_reg[{sel, 2'b00} +: 4];

    always_comb begin
        anode_next   = ~(4'b0001 << sel);
        cathode_next = blank[sel] ? SEG_BLANK : seg_encode(nibble);
    end

    // -----------------------------------------------------------------------
    // Free-running refresh counter and registered outputs. The counter wraps
    // naturally and never stalls, even during a conversion.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_reg <= '0;
            anode_reg   <= 4'b1111;
            cathode_reg <= SEG_BLANK;
        end else begin
            refresh_reg <= refresh_reg + REFRESH_ONE;
            anode_reg   <= anode_next;
            cathode_reg <= cathode_next;
        end
    end

    assign anode   = anode_reg;
    assign cathode = cathode_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_ssd_bcd_display_driver.sv
// ---------------------------------------------------------------------------
// Testbench for ssd_bcd_display_driver (REFRESH_BITS = 4).
//
// The reference model works directly in decimal. For a shown value v and a
// cycle count c since reset release, the active digit is
// ((c-1) mod 16) / 4. The digit is (v / 10^k) mod 10, and it is blanked when
// k > 0 and v < 10^k.
// ---------------------------------------------------------------------------
module tb_ssd_bcd_display_driver;

    localparam int RB    = 4;
    localparam int FRAME = 1 << RB;
    localparam int DWELL = 1 << (RB - 2);

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] value = 13'd0;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc;        // rising edges since reset release
    int shown = 0;  // value the display is expected to show

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int pow10 [4] = '{1, 10, 100, 1000};

    ssd_bcd_display_driver #(.REFRESH_BITS(RB)) dut (
        .clk     (clk),
        .reset   (reset),
        .value   (value),
        .anode   (anode),
        .cathode (cathode),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- reference model ----------------
    function automatic int exp_sel(int c);
        return ((c - 1) % FRAME) / DWELL;
    endfunction

    function automatic logic [3:0] exp_anode(int c);
        logic [3:0] one;
        one = 4'b0001;
        if (c == 0) return 4'b1111;
        return ~(one << exp_sel(c));
    endfunction

    function automatic logic [6:0] exp_cathode(int v, int c);
        int k;
        if (c == 0) return 7'h7F;
        k = exp_sel(c);
        if (k > 0 && v < pow10[k]) return 7'h7F;
        return seg_tab[(v / pow10[k]) % 10];
    endfunction

    // Apply nv in IDLE. Check busy for 15 edges, check that the old value
    // stays on the display meanwhile, then check one full frame of nv.
    task automatic do_conversion(input int nv, input string tag);
        logic       exp_b;
        logic [3:0] ea;
        logic [6:0] ec;
        value = nv[12:0];
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            exp_b = (i < 14);
            ea = exp_anode(cyc);
            ec = exp_cathode(shown, cyc);
            vectors++;
            if (busy !== exp_b) begin
                miscompares++;
                $display("FAIL %s busy after E%0d: got %b want %b", tag, i, busy, exp_b);
            end
            vectors++;
            if (anode !== ea) begin
                miscompares++;
                $display("FAIL %s anode after E%0d: got %b want %b", tag, i, anode, ea);
            end
            vectors++;
            if (cathode !== ec) begin
                miscompares++;
                $display("FAIL %s cathode(old %0d) after E%0d: got %h want %h", tag, shown, i, cathode, ec);
            end
        end
        shown = nv;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            ea = exp_anode(cyc);
            ec = exp_cathode(shown, cyc);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s busy idle: got %b want 0", tag, busy);
            end
            vectors++;
            if (anode !== ea) begin
                miscompares++;
                $display("FAIL %s anode cyc %0d: got %b want %b", tag, cyc, anode, ea);
            end
            vectors++;
            if (cathode !== ec) begin
                miscompares++;
                $display("FAIL %s cathode value %0d cyc %0d: got %h want %h", tag, shown, cyc, cathode, ec);
            end
        end
        $display("txn %s: value %0d converted and displayed", tag, nv);
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic [6:0] ec;
        reset = 1'b1;
        value = 13'd0;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (anode !== 4'b1111 || cathode !== 7'h7F || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset state: got %b/%h/%b want 1111/7f/0", anode, cathode, busy);
            end
        end
        reset = 1'b0;
        shown = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk);
            ea = exp_anode(cyc);
            ec = exp_cathode(0, cyc);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_zero busy cyc %0d: got %b want 0", cyc, busy);
            end
            vectors++;
            if (anode !== ea) begin
                miscompares++;
                $display("FAIL reset_zero anode cyc %0d: got %b want %b", cyc, anode, ea);
            end
            vectors++;
            if (cathode !== ec) begin
                miscompares++;
                $display("FAIL reset_zero cathode cyc %0d: got %h want %h", cyc, cathode, ec);
            end
        end
        $display("txn reset: zero displayed, no conversion");
    endtask

    task automatic test_convert();
        do_conversion(1234, "v1234");
        do_conversion(8191, "v8191");
    endtask

    task automatic test_blanking();
        do_conversion(7, "v7");
        do_conversion(105, "v105");
        do_conversion(1000, "v1000");
        do_conversion(10, "v10");
        do_conversion(0, "v0");
        do_conversion(105, "v105b");
    endtask

    // 1234 is captured at E0, and 4321 is applied after E5. The first result
    // lands at E14, the second capture happens at E15, and LOAD is at E29.
    task automatic test_back_to_back();
        logic       exp_b;
        int         sv;
        logic [3:0] ea;
        logic [6:0] ec;
        value = 13'd1234;
        for (int i = 0; i <= 30 + FRAME; i++) begin
            @(negedge clk);
            exp_b = (i <= 13) || (i >= 15 && i <= 28);
            sv = (i <= 14) ? shown : ((i <= 29) ? 1234 : 4321);
            ea = exp_anode(cyc);
            ec = exp_cathode(sv, cyc);
            vectors++;
            if (busy !== exp_b) begin
                miscompares++;
                $display("FAIL b2b busy after E%0d: got %b want %b", i, busy, exp_b);
            end
            vectors++;
            if (anode !== ea) begin
                miscompares++;
                $display("FAIL b2b anode after E%0d: got %b want %b", i, anode, ea);
            end
            vectors++;
            if (cathode !== ec) begin
                miscompares++;
                $display("FAIL b2b cathode after E%0d (value %0d): got %h want %h", i, sv, cathode, ec);
            end
            if (i == 5) value = 13'd4321;
        end
        shown = 4321;
        $display("txn back_to_back: 1234 then 4321 displayed");
    endtask

    task automatic test_reset_mid();
        value = 13'd999;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_mid busy after E%0d: got %b want 1", i, busy);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (anode !== 4'b1111 || cathode !== 7'h7F || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid async state: got %b/%h/%b want 1111/7f/0", anode, cathode, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        shown = 0;
        $display("txn reset_mid: reset asserted at E7 of 999");
        do_conversion(999, "after_reset_999");
    endtask

    task automatic test_random();
        int nv;
        for (int n = 0; n < 24; n++) begin
            nv = $urandom_range(0, 8191);
            if (nv == shown) nv = (nv + 1) % 8192;
            do_conversion(nv, "random");
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
